register_file: RTL
==================

Name: register_file

Overview:
- Architectural register file for the pipeline: sixteen 32-bit general registers.
- Write side consumes the register-write request stream produced by the stage-2 writeback logic: memory/ALU writes and immediate writes with unsigned, signed, top-half and bottom-half load types.
- Read side serves three combinational read ports to the earlier stages.
- Holds a per-register pending scoreboard so the decode/issue stage can stall on read-after-write hazards.

Parameters:
- BYPASS, 1: when 1, a read of the register being written this cycle returns the new value (write-through); when 0, it returns the old value.
- ZERO_R0, 0: when 1, r0 always reads 0 and writes to it are discarded; when 0, r0 is an ordinary register.

Ports:
- clock  input  1  system clock, all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state
- write  input  1  full-word write strobe, one cycle per write
- write_index  input  4  destination register for write or write_immediate
- write_data  input  32  data for write
- write_immediate  input  1  immediate write strobe
- write_immediate_data  input  16  immediate payload
- write_immediate_type  input  2  00 unsigned, 01 signed, 10 top half, 11 bottom half
- read_reg_a_index  input  4  read port A select
- read_reg_a_data  output  32  read port A data (combinational)
- read_reg_b_index  input  4  read port B select
- read_reg_b_data  output  32  read port B data
- read_reg_c_index  input  4  read port C select
- read_reg_c_data  output  32  read port C data
- claim  input  1  issue stage reserves claim_index as a pending destination
- claim_index  input  4  register being reserved
- cancel  input  1  pipeline flush; clears all pending bits
- pending  output  16  bit n = register n has an outstanding write

Behaviour:
- Reset (asynchronous, active-high): all 16 registers = 32'h0, pending = 16'h0. Read outputs follow combinationally from the cleared contents. Reset asserted mid-write discards that write.
- Write, 1-cycle latency: on the rising edge with write=1, regs[write_index] <= write_data.
- Immediate write: on the rising edge with write_immediate=1, regs[write_index] is updated by type. Sign and zero extension are from bit 15.
  - 00: {16'h0, imm}
  - 01: {{16{imm[15]}}, imm}
  - 10: {imm, old[15:0]}
  - 11: {old[31:16], imm}
- write and write_immediate asserted together: write wins and the immediate is ignored. This is a protocol violation; the bench flags it with an assertion.
- Reads: read_reg_x_data = regs[read_reg_x_index], purely combinational.
  - BYPASS=1 and a write or immediate targets the same index in the same cycle: the port returns the value that will be stored at the edge. For types 10/11 this is the merged value.
  - BYPASS=0: the port returns the stored (old) value.
- ZERO_R0=1: reads of index 0 return 0 and the bypass never applies to r0. Writes to r0 do not modify it but still clear pending[0]. claim of r0 is ignored.
- Scoreboard, evaluated per rising edge in priority order:
  1. cancel=1: pending <= 0. A claim in the same cycle is also dropped.
  2. Otherwise, a write or write_immediate to index n clears pending[n].
  3. Then claim=1 sets pending[claim_index].
- Simultaneous retire and claim of the same index leaves the bit set, because the newer claim wins.
- Claiming an already-pending register keeps the bit set. There is no count, so the issue stage stalls rather than double-claiming.
- pending is registered and visible the cycle after the claim edge.
- No flags or ALU state are held here; condition flags remain in stage 2.

Test Plan:
- Reset asserted with random prior contents -> all three read ports = 32'h0 for every index; pending = 16'h0.
- write=1, index 3, data 32'hDEADBEEF; next cycle read A index 3 -> 32'hDEADBEEF. Same-cycle read with BYPASS=1 -> 32'hDEADBEEF; with BYPASS=0 -> 32'h0.
- Immediate writes on r5, in order:
  - type 01, imm 16'h8001 -> r5 = 32'hFFFF8001
  - type 10, imm 16'h1234 -> r5 = 32'h12348001
  - type 11, imm 16'hABCD -> r5 = 32'h1234ABCD
  - type 00, imm 16'h8001 -> r5 = 32'h00008001
- Claim r7 -> pending = 16'h0080. Write r7 with a simultaneous claim of r2 -> pending = 16'h0004. Claim r2 with a simultaneous write r2 -> bit 2 stays set. Cancel -> pending = 0.
- ZERO_R0=1: write 32'h55 to r0 -> all ports read r0 as 0, and pending[0] stays 0 after a claim of r0.
- Reset pulsed asynchronously between edges during a write burst -> contents and pending clear immediately, and the in-flight write is not applied.

Source files
------------

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module   : register_file
//  Purpose  : Sixteen 32-bit architectural registers with three combinational
//             read ports, one write port (full word or 16-bit immediate with
//             unsigned/signed/top-half/bottom-half merge) and a per-register
//             pending scoreboard for read-after-write hazard stalls.
//  Ports    : clock, reset                 - clock, async active-high reset
//             write, write_data            - full-word write strobe / data
//             write_immediate(_data/_type) - immediate write strobe/payload/type
//             write_index                  - destination for either write
//             read_reg_{a,b,c}_index/_data - combinational read ports
//             claim, claim_index           - reserve a pending destination
//             cancel                       - flush: clear all pending bits
//             pending                      - bit n set = r[n] write outstanding
//  Revision : 1.0  initial release
// ============================================================================
module register_file #(
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write,
  input  logic [3:0]  write_index,
  input  logic [31:0] write_data,
  input  logic        write_immediate,
  input  logic [15:0] write_immediate_data,
  input  logic [1:0]  write_immediate_type,
  input  logic [3:0]  read_reg_a_index,
  output logic [31:0] read_reg_a_data,
  input  logic [3:0]  read_reg_b_index,
  output logic [31:0] read_reg_b_data,
  input  logic [3:0]  read_reg_c_index,
  output logic [31:0] read_reg_c_data,
  input  logic        claim,
  input  logic [3:0]  claim_index,
  input  logic        cancel,
  output logic [15:0] pending
);

  localparam logic [1:0] IMM_UNSIGNED = 2'b00;
  localparam logic [1:0] IMM_SIGNED   = 2'b01;
  localparam logic [1:0] IMM_TOP      = 2'b10;
  localparam logic [1:0] IMM_BOTTOM   = 2'b11;

  logic [31:0] regs_q [16];
  logic [31:0] regs_d [16];
  logic [15:0] pending_q;
  logic [15:0] pending_d;

  logic        w_wr_en;     // any write request this cycle
  logic        w_store;     // request actually modifies the array
  logic [31:0] w_old;
  logic [31:0] w_wr_val;    // value that lands at the edge (merged for halves)

  assign w_wr_en = write | write_immediate;
  assign w_store = w_wr_en & ~(ZERO_R0 && (write_index == 4'd0));
  assign w_old   = regs_q[write_index];

  // Full-word write has priority over a simultaneous immediate.
  always_comb begin
    w_wr_val = write_data;
    if (!write) begin
      case (write_immediate_type)
        IMM_UNSIGNED: w_wr_val = {16'h0000, write_immediate_data};
        IMM_SIGNED:   w_wr_val = {{16{write_immediate_data[15]}}, write_immediate_data};
        IMM_TOP:      w_wr_val = {write_immediate_data, w_old[15:0]};
        IMM_BOTTOM:   w_wr_val = {w_old[31:16], write_immediate_data};
        default:      w_wr_val = write_data;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (w_store) begin
      regs_d[write_index] = w_wr_val;
    end
  end

  // Retire clears before claim sets, so a same-index claim wins.
  always_comb begin
    pending_d = pending_q;
    if (cancel) begin
      pending_d = 16'h0000;
    end else begin
      if (w_wr_en) begin
        pending_d[write_index] = 1'b0;
      end
      if (claim && !(ZERO_R0 && (claim_index == 4'd0))) begin
        pending_d[claim_index] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= 32'h0000_0000;
      end
      pending_q <= 16'h0000;
    end else begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

  // Read ports share one implementation, indexed 0=A, 1=B, 2=C.
  logic [3:0]  rd_idx  [3];
  logic [31:0] rd_data [3];

  assign rd_idx[0] = read_reg_a_index;
  assign rd_idx[1] = read_reg_b_index;
  assign rd_idx[2] = read_reg_c_index;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_read
      always_comb begin
        rd_data[gi] = regs_q[rd_idx[gi]];
        if (ZERO_R0 && (rd_idx[gi] == 4'd0)) begin
          rd_data[gi] = 32'h0000_0000;
        end else if (BYPASS && w_store && (rd_idx[gi] == write_index)) begin
          rd_data[gi] = w_wr_val;
        end
      end
    end
  endgenerate

  assign read_reg_a_data = rd_data[0];
  assign read_reg_b_data = rd_data[1];
  assign read_reg_c_data = rd_data[2];

endmodule
`default_nettype wire
